// File: rtl/fifo_sync_prog_if.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_sync_prog_if
//  Purpose  : Handshake/status bundle between a FIFO user and fifo_sync_prog.
//  Revision : 1.0  initial release
// ============================================================================
interface fifo_sync_prog_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int PTR_WIDTH = $clog2(DEPTH);

    logic                 wr_en;
    logic [WIDTH-1:0]     wdata;
    logic                 rd_en;
    logic                 err_clr;
    logic [WIDTH-1:0]     rdata;
    logic                 rd_valid;
    logic                 full;
    logic                 empty;
    logic                 almost_full;
    logic                 almost_empty;
    logic [PTR_WIDTH:0]   count;
    logic                 wr_err;
    logic                 rd_err;

    modport master (
        output wr_en, wdata, rd_en, err_clr,
        input  rdata, rd_valid, full, empty, almost_full, almost_empty,
               count, wr_err, rd_err
    );

    modport slave (
        input  wr_en, wdata, rd_en, err_clr,
        output rdata, rd_valid, full, empty, almost_full, almost_empty,
               count, wr_err, rd_err
    );
endinterface
`default_nettype wire

// File: rtl/fifo_sync_prog.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_sync_prog
//  Purpose  : Parametrised single-clock FIFO with occupancy count, programmable
//             almost flags, sticky error flags and optional FWFT read mode.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_sync_prog #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int PTR_WIDTH = $clog2(DEPTH),
    parameter int AF_LEVEL  = DEPTH - 2,
    parameter int AE_LEVEL  = 2,
    parameter int FWFT      = 0
) (
    input  wire logic          clk,
    input  wire logic          rst,
    fifo_sync_prog_if.slave    bus
);

    localparam logic [PTR_WIDTH:0] c_PTR_ONE  = (PTR_WIDTH + 1)'(1);
    localparam logic [PTR_WIDTH:0] c_AF_LEVEL = (PTR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [PTR_WIDTH:0] c_AE_LEVEL = (PTR_WIDTH + 1)'(AE_LEVEL);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // ------------------------------------------------------------------
    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
            $error("fifo_sync_prog: DEPTH must be a power of two >= 2");
        end
        if (PTR_WIDTH != $clog2(DEPTH)) begin : g_chk_ptr
            $error("fifo_sync_prog: PTR_WIDTH is derived from DEPTH");
        end
        if ((AF_LEVEL > DEPTH) || (AF_LEVEL < 0)) begin : g_chk_af
            $error("fifo_sync_prog: AF_LEVEL out of range");
        end
        if ((AE_LEVEL >= DEPTH) || (AE_LEVEL < 0)) begin : g_chk_ae
            $error("fifo_sync_prog: AE_LEVEL out of range");
        end
        if (WIDTH < 1) begin : g_chk_width
            $error("fifo_sync_prog: WIDTH must be >= 1");
        end
    endgenerate

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_WIDTH:0]   r_wr_ptr;
    logic [PTR_WIDTH:0]   r_rd_ptr;
    logic                 r_wr_err;
    logic                 r_rd_err;

    logic [PTR_WIDTH-1:0] w_wr_addr;
    logic [PTR_WIDTH-1:0] w_rd_addr;
    logic                 w_full;
    logic                 w_empty;
    logic [PTR_WIDTH:0]   w_count;
    logic                 w_rd_acc;
    logic                 w_wr_acc;
    logic                 w_wr_rej;
    logic                 w_rd_rej;

    assign w_wr_addr = r_wr_ptr[PTR_WIDTH-1:0];
    assign w_rd_addr = r_rd_ptr[PTR_WIDTH-1:0];

    assign w_full  = (r_wr_ptr[PTR_WIDTH] != r_rd_ptr[PTR_WIDTH]) &&
                     (w_wr_addr == w_rd_addr);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_count = r_wr_ptr - r_rd_ptr;

    // A write into a full FIFO is legal only when a read frees a slot the same cycle
    assign w_rd_acc = bus.rd_en && !w_empty;
    assign w_wr_acc = bus.wr_en && (!w_full || w_rd_acc);
    assign w_wr_rej = bus.wr_en && !w_wr_acc;
    assign w_rd_rej = bus.rd_en && w_empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_wr_err <= 1'b0;
            r_rd_err <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            // A new error in the same cycle as err_clr wins
            if (w_wr_rej) begin
                r_wr_err <= 1'b1;
            end else if (bus.err_clr) begin
                r_wr_err <= 1'b0;
            end
            if (w_rd_rej) begin
                r_rd_err <= 1'b1;
            end else if (bus.err_clr) begin
                r_rd_err <= 1'b0;
            end
        end
    end

    // Storage is not reset; reset only blocks writes in that cycle
    always_ff @(posedge clk) begin
        if (rst && w_wr_acc) begin
            mem[w_wr_addr] <= bus.wdata;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.rdata    = mem[w_rd_addr];
            assign bus.rd_valid = !w_empty;
        end else begin : g_std
            logic [WIDTH-1:0] r_rdata;
            logic             r_rd_valid;

            // Nonblocking memory write means a same-address read returns the old word
            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_rdata    <= '0;
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_rdata <= mem[w_rd_addr];
                    end
                end
            end

            assign bus.rdata    = r_rdata;
            assign bus.rd_valid = r_rd_valid;
        end
    endgenerate

    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.count        = w_count;
    assign bus.almost_full  = (w_count >= c_AF_LEVEL);
    assign bus.almost_empty = (w_count <= c_AE_LEVEL);
    assign bus.wr_err       = r_wr_err;
    assign bus.rd_err       = r_rd_err;

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_prog.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_sync_prog
//  Purpose  : Directed self-checking bench for default and FWFT configurations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo_sync_prog;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    fifo_sync_prog_if #(.WIDTH(8),  .DEPTH(16)) d_if ();
    fifo_sync_prog_if #(.WIDTH(12), .DEPTH(4))  f_if ();

    fifo_sync_prog #(.WIDTH(8), .DEPTH(16)) u_dut_std (
        .clk (clk),
        .rst (rst),
        .bus (d_if.slave)
    );

    fifo_sync_prog #(.WIDTH(12), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)) u_dut_fwft (
        .clk (clk),
        .rst (rst),
        .bus (f_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic d_idle();
        d_if.wr_en   = 1'b0;
        d_if.rd_en   = 1'b0;
        d_if.err_clr = 1'b0;
        d_if.wdata   = '0;
    endtask

    // FWFT vectors: {wr, rd, data}; spans a pointer wrap on the 4-deep FIFO
    localparam int NV = 13;
    logic        v_wr [NV] = '{1,1,1,1,1,1,0,0,1,0,0,0,0};
    logic        v_rd [NV] = '{0,0,0,1,0,1,1,1,0,1,1,1,1};
    logic [11:0] v_dat[NV] = '{12'h101,12'h202,12'h303,12'h404,12'h505,12'h606,
                               12'h000,12'h000,12'h707,12'h000,12'h000,12'h000,12'h000};

    initial begin
        logic [11:0] q[$];
        logic        rd_acc;
        logic        wr_acc;
        logic [7:0]  exp8;

        n_cmp = 0;
        n_err = 0;
        d_idle();
        f_if.wr_en = 1'b0; f_if.rd_en = 1'b0; f_if.err_clr = 1'b0; f_if.wdata = '0;

        // Reset with random traffic on the default instance
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            d_if.wr_en = 1'($urandom_range(0, 1));
            d_if.rd_en = 1'($urandom_range(0, 1));
            d_if.wdata = 8'($urandom);
            tick();
        end
        d_idle();
        chk_eq("rst_count",    32'(d_if.count),        32'd0);
        chk_eq("rst_empty",    32'(d_if.empty),        32'd1);
        chk_eq("rst_full",     32'(d_if.full),         32'd0);
        chk_eq("rst_ae",       32'(d_if.almost_empty), 32'd1);
        chk_eq("rst_af",       32'(d_if.almost_full),  32'd0);
        chk_eq("rst_rd_valid", 32'(d_if.rd_valid),     32'd0);
        chk_eq("rst_rdata",    32'(d_if.rdata),        32'd0);
        chk_eq("rst_wr_err",   32'(d_if.wr_err),       32'd0);
        chk_eq("rst_rd_err",   32'(d_if.rd_err),       32'd0);
        chk_eq("rst_f_count",  32'(f_if.count),        32'd0);
        rst = 1'b1;
        tick();

        // Fill 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            d_if.wr_en = 1'b1;
            d_if.wdata = 8'(i);
            tick();
            chk_eq("fill_count", 32'(d_if.count),        32'(i));
            chk_eq("fill_full",  32'(d_if.full),         (i == 16) ? 32'd1 : 32'd0);
            chk_eq("fill_af",    32'(d_if.almost_full),  (i >= 14) ? 32'd1 : 32'd0);
            chk_eq("fill_ae",    32'(d_if.almost_empty), (i <= 2)  ? 32'd1 : 32'd0);
        end

        // Overflow with no read
        d_if.wdata = 8'hEE;
        tick();
        d_idle();
        chk_eq("ovf_wr_err", 32'(d_if.wr_err), 32'd1);
        chk_eq("ovf_count",  32'(d_if.count),  32'd16);
        chk_eq("ovf_rd_err", 32'(d_if.rd_err), 32'd0);

        d_if.err_clr = 1'b1;
        tick();
        d_idle();
        chk_eq("clr_wr_err", 32'(d_if.wr_err), 32'd0);

        // Read and write together while full
        d_if.wr_en = 1'b1;
        d_if.rd_en = 1'b1;
        d_if.wdata = 8'hAA;
        tick();
        d_idle();
        chk_eq("sim_full_wr_err", 32'(d_if.wr_err),   32'd0);
        chk_eq("sim_full_count",  32'(d_if.count),    32'd16);
        chk_eq("sim_full_valid",  32'(d_if.rd_valid), 32'd1);
        chk_eq("sim_full_rdata",  32'(d_if.rdata),    32'h01);

        // Drain: 0x02..0x10 then 0xAA
        for (int i = 0; i < 16; i++) begin
            d_if.rd_en = 1'b1;
            tick();
            exp8 = (i < 15) ? 8'(i + 2) : 8'hAA;
            chk_eq("drain_valid", 32'(d_if.rd_valid),     32'd1);
            chk_eq("drain_rdata", 32'(d_if.rdata),        32'(exp8));
            chk_eq("drain_count", 32'(d_if.count),        32'(15 - i));
            chk_eq("drain_ae",    32'(d_if.almost_empty), (15 - i <= 2) ? 32'd1 : 32'd0);
        end
        d_idle();
        tick();
        chk_eq("idle_valid", 32'(d_if.rd_valid), 32'd0);
        chk_eq("idle_rdata", 32'(d_if.rdata),    32'hAA);
        chk_eq("idle_empty", 32'(d_if.empty),    32'd1);

        // Underflow, then clear racing a new error
        d_if.rd_en = 1'b1;
        tick();
        chk_eq("udf_rd_err", 32'(d_if.rd_err),   32'd1);
        chk_eq("udf_valid",  32'(d_if.rd_valid), 32'd0);
        chk_eq("udf_count",  32'(d_if.count),    32'd0);
        d_if.err_clr = 1'b1;
        tick();
        chk_eq("clr_vs_set", 32'(d_if.rd_err), 32'd1);
        d_if.rd_en = 1'b0;
        tick();
        chk_eq("clr_rd_err", 32'(d_if.rd_err), 32'd0);
        d_idle();

        // Read and write together while empty: read rejected, write kept
        d_if.wr_en = 1'b1;
        d_if.rd_en = 1'b1;
        d_if.wdata = 8'h55;
        tick();
        d_idle();
        chk_eq("sim_empty_rd_err", 32'(d_if.rd_err),   32'd1);
        chk_eq("sim_empty_count",  32'(d_if.count),    32'd1);
        chk_eq("sim_empty_valid",  32'(d_if.rd_valid), 32'd0);
        d_if.rd_en = 1'b1;
        tick();
        d_idle();
        chk_eq("rd55_valid", 32'(d_if.rd_valid), 32'd1);
        chk_eq("rd55_rdata", 32'(d_if.rdata),    32'h55);
        chk_eq("rd55_count", 32'(d_if.count),    32'd0);

        // Reset mid-operation discards stored data
        for (int i = 0; i < 3; i++) begin
            d_if.wr_en = 1'b1;
            d_if.wdata = 8'(8'h30 + i);
            tick();
        end
        d_idle();
        chk_eq("pre_rst_count", 32'(d_if.count), 32'd3);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk_eq("mid_rst_count", 32'(d_if.count),  32'd0);
        chk_eq("mid_rst_empty", 32'(d_if.empty),  32'd1);
        chk_eq("mid_rst_rdata", 32'(d_if.rdata),  32'd0);
        chk_eq("mid_rst_err",   32'(d_if.rd_err), 32'd0);

        // FWFT instance across the pointer wrap
        for (int i = 0; i < NV; i++) begin
            f_if.wr_en = v_wr[i];
            f_if.rd_en = v_rd[i];
            f_if.wdata = v_dat[i];
            #1;
            rd_acc = v_rd[i] && (q.size() > 0);
            wr_acc = v_wr[i] && ((q.size() < 4) || rd_acc);
            if (rd_acc) begin
                chk_eq("fwft_head", 32'(f_if.rdata), 32'(q[0]));
            end
            tick();
            if (rd_acc) void'(q.pop_front());
            if (wr_acc) q.push_back(v_dat[i]);
            chk_eq("fwft_count", 32'(f_if.count),    32'(q.size()));
            chk_eq("fwft_valid", 32'(f_if.rd_valid), (q.size() > 0) ? 32'd1 : 32'd0);
            if (q.size() > 0) begin
                chk_eq("fwft_rdata", 32'(f_if.rdata), 32'(q[0]));
            end
        end
        f_if.wr_en = 1'b0;
        f_if.rd_en = 1'b0;
        chk_eq("fwft_wr_err", 32'(f_if.wr_err), 32'd0);
        chk_eq("fwft_rd_err", 32'(f_if.rd_err), 32'd1);
        chk_eq("fwft_empty",  32'(f_if.empty),  32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
